// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_pkg
//  Description : Constants and types shared by the QPSK transmit filter and
//                the receive-side BER checker.
//  Revision    : 1.0  initial release
// ============================================================================
package qpsk_pkg;

  // Shaped sample width and oversampling ratio of the transmit filter
  localparam int SAMPLE_W  = 16;
  localparam int OS_FACTOR = 4;

  // Default BER checker sizing
  localparam int DEF_DELAY_MAX = 64;
  localparam int DEF_WINDOW    = 511;
  localparam int DEF_CNT_W     = 64;

  // BER checker control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } ber_state_e;

endpackage
`default_nettype wire

// File: rtl/ber_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : ber_checker_if
//  Description : Data, reference and status bundle of the BER checker.
//                slave = checker side, master = driver/monitor side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ber_checker_if
  import qpsk_pkg::*;
#(
  parameter int DELAY_MAX = DEF_DELAY_MAX,
  parameter int CNT_W     = DEF_CNT_W
) ();

  localparam int DELAY_W = $clog2(DELAY_MAX);

  logic signed [SAMPLE_W-1:0] i_sample;
  logic [1:0]                 i_phase;
  logic                       i_ref_bit;
  logic                       i_ref_valid;
  logic                       i_enable;
  logic                       o_sym_bit;
  logic                       o_sym_valid;
  logic                       o_locked;
  logic [DELAY_W-1:0]         o_delay;
  logic [CNT_W-1:0]           o_err_count;
  logic [CNT_W-1:0]           o_bit_count;

  modport slave (
    input  i_sample, i_phase, i_ref_bit, i_ref_valid, i_enable,
    output o_sym_bit, o_sym_valid, o_locked, o_delay, o_err_count, o_bit_count
  );

  modport master (
    output i_sample, i_phase, i_ref_bit, i_ref_valid, i_enable,
    input  o_sym_bit, o_sym_valid, o_locked, o_delay, o_err_count, o_bit_count
  );

endinterface
`default_nettype wire

// File: rtl/sym_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : sym_slicer
//  Description : Picks one sample per symbol at a selectable phase of a
//                free-running oversampling counter and hard-slices it.
//  Revision    : 1.0  initial release
// ============================================================================
module sym_slicer
  import qpsk_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [1:0]          i_phase,
  output logic                o_strobe,     // this cycle is the chosen phase
  output logic                o_bit_next,   // slice of the current sample
  output logic                o_sym_bit,
  output logic                o_sym_valid
);

  localparam int PH_W = $clog2(OS_FACTOR);

  logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
  logic            sym_bit_q, sym_bit_d;
  logic            sym_valid_q, sym_valid_d;

  // A hard decision needs only the sign; magnitude bits are deliberately dropped
  logic unused_mag_bits;
  assign unused_mag_bits = ^i_sample[SAMPLE_W-2:0];

  // Zero counts as positive, so the slice is simply the inverted sign bit
  assign o_strobe   = (phase_cnt_q == i_phase);
  assign o_bit_next = ~i_sample[SAMPLE_W-1];

  // Next-state: free-running phase counter, sliced bit held between strobes
  always_comb begin
    phase_cnt_d = phase_cnt_q + PH_W'(1);
    sym_bit_d   = o_strobe ? o_bit_next : sym_bit_q;
    sym_valid_d = o_strobe;
  end

  // Register counter and sliced outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt_q <= '0;
      sym_bit_q   <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      sym_bit_q   <= sym_bit_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign o_sym_bit   = sym_bit_q;
  assign o_sym_valid = sym_valid_q;

endmodule
`default_nettype wire

// File: rtl/ber_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ber_checker
//  Description : Receive-side BER checker for one QPSK branch. Decimates and
//                slices the shaped stream, finds the reference alignment by
//                exhaustive delay search, then counts bits and errors.
//  Revision    : 1.0  initial release
// ============================================================================
module ber_checker
  import qpsk_pkg::*;
#(
  parameter int DELAY_MAX = DEF_DELAY_MAX,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  ber_checker_if.slave  bus
);

  localparam int DW = $clog2(DELAY_MAX);
  localparam int EW = $clog2(WINDOW + 1);   // holds 0..WINDOW errors

  logic strobe;
  logic bit_next;

  sym_slicer u_slicer (
    .clk         (clk),
    .reset       (reset),
    .i_sample    (bus.i_sample),
    .i_phase     (bus.i_phase),
    .o_strobe    (strobe),
    .o_bit_next  (bit_next),
    .o_sym_bit   (bus.o_sym_bit),
    .o_sym_valid (bus.o_sym_valid)
  );

  ber_state_e             state_q, state_d;
  logic [DELAY_MAX-1:0]   ref_sr_q, ref_sr_d;
  logic [DW-1:0]          d_q, d_d;
  logic [DW-1:0]          best_d_q, best_d_d;
  logic [DW-1:0]          delay_q, delay_d;
  logic [EW-1:0]          win_cnt_q, win_cnt_d;
  logic [EW-1:0]          cur_err_q, cur_err_d;
  logic [EW-1:0]          min_err_q, min_err_d;
  logic                   locked_q, locked_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;

  logic [DW-1:0]          sel_d;
  logic                   err;
  logic [EW-1:0]          cur_sum;
  logic [DW-1:0]          best_v;
  logic [EW-1:0]          min_v;

  // The compare taps ref_sr before this cycle's shift, so a reference strobe
  // landing on a symbol strobe does not disturb the comparison
  assign sel_d   = (state_q == LOCKED) ? delay_q : d_q;
  assign err     = bit_next ^ ref_sr_q[sel_d];
  assign cur_sum = cur_err_q + EW'(err);

  // Next-state: reference shift register, search/lock control and counters
  always_comb begin
    state_d   = state_q;
    ref_sr_d  = ref_sr_q;
    d_d       = d_q;
    best_d_d  = best_d_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    cur_err_d = cur_err_q;
    min_err_d = min_err_q;
    locked_d  = locked_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    best_v    = best_d_q;
    min_v     = min_err_q;

    if (bus.i_ref_valid) begin
      ref_sr_d = {ref_sr_q[DELAY_MAX-2:0], bus.i_ref_bit};
    end

    case (state_q)
      IDLE: begin
        if (bus.i_enable) begin
          state_d   = SEARCH;
          d_d       = '0;
          win_cnt_d = '0;
          cur_err_d = '0;
          min_err_d = '1;
          err_cnt_d = '0;
          bit_cnt_d = '0;
          locked_d  = 1'b0;
        end
      end

      SEARCH: begin
        if (!bus.i_enable) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (strobe) begin
          if (win_cnt_q == EW'(WINDOW - 1)) begin
            // Strict compare: on a tie the earlier (smaller) delay wins
            if (cur_sum < min_err_q) begin
              min_v  = cur_sum;
              best_v = d_q;
            end
            min_err_d = min_v;
            best_d_d  = best_v;
            cur_err_d = '0;
            win_cnt_d = '0;
            if (d_q == DW'(DELAY_MAX - 1)) begin
              delay_d  = best_v;
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              d_d = d_q + DW'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q + EW'(1);
            cur_err_d = cur_sum;
          end
        end
      end

      LOCKED: begin
        if (!bus.i_enable) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (strobe) begin
          // Both counters stick at all-ones rather than wrapping
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // Register all checker state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ref_sr_q  <= '0;
      d_q       <= '0;
      best_d_q  <= '0;
      delay_q   <= '0;
      win_cnt_q <= '0;
      cur_err_q <= '0;
      min_err_q <= '1;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_sr_q  <= ref_sr_d;
      d_q       <= d_d;
      best_d_q  <= best_d_d;
      delay_q   <= delay_d;
      win_cnt_q <= win_cnt_d;
      cur_err_q <= cur_err_d;
      min_err_q <= min_err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.o_locked    = locked_q;
  assign bus.o_delay     = delay_q;
  assign bus.o_err_count = err_cnt_q;
  assign bus.o_bit_count = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ber_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ber_checker
//  Description : Directed self-checking bench for ber_checker, built with a
//                small search (4 delays x 8 symbols) and 5-bit counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ber_checker;
  import qpsk_pkg::*;

  localparam int DM  = 4;
  localparam int WIN = 8;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ber_checker_if #(.DELAY_MAX(DM), .CNT_W(CW)) bus ();

  ber_checker #(.DELAY_MAX(DM), .WINDOW(WIN), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          pc    = 0;      // tb copy of the free-running phase counter
  int          sn    = 0;      // symbol index (strobes seen)
  int          nstr  = 0;      // strobes seen while the DUT is out of IDLE
  bit          armed = 1'b0;
  bit          chk   = 1'b0;
  logic        exp_bit = 1'b0;
  int          mode  = 0;      // 0: constant sample/ref, 1: PRBS3 pattern
  logic [15:0] cs    = 16'd0;
  logic        cr    = 1'b0;
  logic [6:0]  pat   = 7'b1110100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic pbit(input int i);
    int m;
    m = ((i % 7) + 7) % 7;
    return pat[6 - m];
  endfunction

  // One clock: drive the symbol data, ref strobe on the chosen phase
  task automatic tick();
    logic        strobe;
    logic [15:0] s;
    logic        rb;
    strobe = (pc[1:0] == bus.i_phase);
    if (mode == 1) begin
      s  = pbit(sn - 3) ? 16'sd1000 : -16'sd1000;
      rb = pbit(sn);
    end else begin
      s  = cs;
      rb = cr;
    end
    bus.i_sample    = s;
    bus.i_ref_bit   = rb;
    bus.i_ref_valid = strobe;
    if (strobe) begin
      sn++;
      exp_bit = ~s[15];
    end
    if (armed && strobe) nstr++;
    @(posedge clk);
    #1;
    pc    = (pc + 1) % 4;
    armed = bus.i_enable;
    if (chk) begin
      check("sym_valid", {63'd0, bus.o_sym_valid}, {63'd0, strobe});
      check("sym_bit", {63'd0, bus.o_sym_bit}, {63'd0, exp_bit});
    end
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 1000 && nstr < n; i++) tick();
    check("strobe_budget", 64'(nstr), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_bit"},   {63'd0, bus.o_sym_bit},   64'd0);
    check({tag, "_sym_valid"}, {63'd0, bus.o_sym_valid}, 64'd0);
    check({tag, "_locked"},    {63'd0, bus.o_locked},    64'd0);
    check({tag, "_delay"},     64'(bus.o_delay),         64'd0);
    check({tag, "_err"},       64'(bus.o_err_count),     64'd0);
    check({tag, "_bits"},      64'(bus.o_bit_count),     64'd0);
  endtask

  initial begin
    // ---- reset ----
    reset = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_phase  = 2'd0;
    bus.i_sample = '0;
    bus.i_ref_bit = 1'b0;
    bus.i_ref_valid = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    pc = 0;
    exp_bit = 1'b0;
    chk = 1'b1;

    // ---- slicing: zero is positive, sign bit set is negative ----
    cs = 16'h0000; cr = 1'b1;
    repeat (4) tick();
    check("slice_zero", {63'd0, bus.o_sym_bit}, 64'd1);
    cs = 16'h8000;
    repeat (4) tick();
    check("slice_neg", {63'd0, bus.o_sym_bit}, 64'd0);

    // ---- every phase, constant +100 with ref 1: no errors, delay 0 ----
    cs = 16'd100; cr = 1'b1;
    for (int p = 0; p < 4; p++) begin
      bus.i_phase = p[1:0];
      repeat (20) tick();
      nstr = 0;
      bus.i_enable = 1'b1;
      run_to(32);
      check("ph_locked", {63'd0, bus.o_locked}, 64'd1);
      check("ph_delay",  64'(bus.o_delay),      64'd0);
      run_to(35);
      check("ph_bits", 64'(bus.o_bit_count), 64'd3);
      check("ph_err",  64'(bus.o_err_count), 64'd0);
      bus.i_enable = 1'b0;
      tick();
      check("ph_unlock", {63'd0, bus.o_locked}, 64'd0);
    end

    // ---- PRBS3 stream, data lags reference by 3 symbols: delay 2 ----
    bus.i_phase = 2'd1;
    mode = 1;
    repeat (32) tick();
    nstr = 0;
    bus.i_enable = 1'b1;
    run_to(31);
    check("pat_not_yet_locked", {63'd0, bus.o_locked}, 64'd0);
    run_to(32);
    check("pat_locked", {63'd0, bus.o_locked}, 64'd1);
    check("pat_delay",  64'(bus.o_delay),      64'd2);
    run_to(42);
    check("pat_bits", 64'(bus.o_bit_count), 64'd10);
    check("pat_err",  64'(bus.o_err_count), 64'd0);

    // enable drop in LOCKED: unlock, hold delay and counters
    bus.i_enable = 1'b0;
    tick();
    check("drop_locked", {63'd0, bus.o_locked}, 64'd0);
    check("drop_delay",  64'(bus.o_delay),      64'd2);
    check("drop_bits",   64'(bus.o_bit_count),  64'd10);
    repeat (12) tick();
    check("hold_bits", 64'(bus.o_bit_count), 64'd10);
    check("hold_err",  64'(bus.o_err_count), 64'd0);

    // re-enable clears counters and restarts the search
    nstr = 0;
    bus.i_enable = 1'b1;
    tick();
    check("reen_bits",   64'(bus.o_bit_count),  64'd0);
    check("reen_locked", {63'd0, bus.o_locked}, 64'd0);
    check("reen_delay",  64'(bus.o_delay),      64'd2);
    run_to(10);

    // reset in the middle of SEARCH
    bus.i_enable = 1'b0;
    reset = 1'b1;
    chk = 1'b0;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    pc = 0;
    exp_bit = 1'b0;
    chk = 1'b1;

    // ---- inverted reference: all delays tie, delay 0, every bit an error ----
    bus.i_phase = 2'd3;
    mode = 0;
    cs = 16'd100; cr = 1'b0;
    repeat (20) tick();
    nstr = 0;
    bus.i_enable = 1'b1;
    run_to(32);
    check("inv_locked", {63'd0, bus.o_locked}, 64'd1);
    check("inv_delay",  64'(bus.o_delay),      64'd0);
    run_to(42);
    check("inv_err",  64'(bus.o_err_count), 64'd10);
    check("inv_bits", 64'(bus.o_bit_count), 64'd10);

    // ---- saturation: 35 locked symbols into 5-bit counters ----
    run_to(67);
    check("sat_bits", 64'(bus.o_bit_count), 64'd31);
    check("sat_err",  64'(bus.o_err_count), 64'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ber_checker.md
# ber_checker

Receive-side bit-error-rate checker for one QPSK branch. It sits directly downstream of the transmit pulse-shaping filter, which produces one sample per clock at 4 samples/symbol. The block does three things:
- decimates the 16-bit shaped stream to one sample per symbol at a selectable phase;
- hard-slices each decimated sample to a bit;
- aligns the sliced bits against the transmitted reference bit stream by exhaustive delay search, then counts bits and errors.

## Interface
Parameters:
- DELAY_MAX, 64: number of candidate alignment delays searched (0..DELAY_MAX-1); also the depth of the reference shift register.
- WINDOW, 511: symbols compared per candidate delay during search.
- CNT_W, 64: width of bit and error counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- i_sample  in  16  signed shaped sample, one per clk.
- i_phase  in  2  decimation phase, 0..3.
- i_ref_bit  in  1  transmitted bit (1 maps to +, 0 maps to -).
- i_ref_valid  in  1  strobe: i_ref_bit is valid this cycle, once per symbol.
- i_enable  in  1  run control; low forces IDLE.
- o_sym_bit  out  1  last sliced bit.
- o_sym_valid  out  1  one-cycle pulse when o_sym_bit updates.
- o_locked  out  1  high in LOCKED.
- o_delay  out  6 (clog2 DELAY_MAX)  chosen alignment delay.
- o_err_count  out  CNT_W  errors counted in LOCKED.
- o_bit_count  out  CNT_W  bits compared in LOCKED.

## Operation
Decimation and slicing:
- phase_cnt is a free-running 2-bit counter; reset sets it to 0; it wraps 3→0.
- Symbol strobe: phase_cnt == i_phase.
- On the strobe, o_sym_bit is set to ~i_sample[15], so a sample of 0 slices as 1.
- A change on i_phase takes effect at the next counter match; it does not restart the search.

Reference buffering:
- ref_sr is a DELAY_MAX-bit shift register that shifts in i_ref_bit on i_ref_valid.
- ref_sr[d] is the reference bit delayed by d symbols.

Comparison:
- Performed on each symbol strobe: err = o_sym_bit_next XOR ref_sr[d].
- d is the candidate delay during SEARCH and o_delay during LOCKED.
- ref_sr is read before that cycle's shift.

FSM:
- IDLE:
  - counters hold their values.
  - Leaves to SEARCH when i_enable=1. On entry to SEARCH: d=0, win_cnt=0, cur_err=0, min_err=all-ones, o_err_count and o_bit_count cleared, o_locked=0.
- SEARCH:
  - On each strobe, cur_err += err and win_cnt++.
  - When win_cnt reaches WINDOW-1 with a strobe:
    - if the final cur_err < min_err (strictly less), set min_err = final cur_err and best_d = d. On a tie the smaller delay is kept.
    - then d++, cur_err=0, win_cnt=0.
  - After d = DELAY_MAX-1 completes, set o_delay=best_d and go to LOCKED.
- LOCKED:
  - o_locked=1.
  - On each strobe, o_bit_count++ and o_err_count += err.
  - Both counters saturate at all-ones and never wrap.
- Any state with i_enable=0 goes to IDLE next cycle. o_locked clears; o_delay and the counters hold.
- reset returns to IDLE from any state.

Reset values: every output is 0; phase_cnt, ref_sr, d, best_d, win_cnt, cur_err are 0; min_err is all-ones.

## Timing
- o_sym_bit and o_sym_valid are registered: o_sym_valid goes high the cycle after the strobe cycle.
- o_bit_count and o_err_count update the cycle after the strobe.
- Total search duration is DELAY_MAX·WINDOW symbols; at the defaults that is 32704 symbols = 130816 clk.
- o_locked rises the cycle after the last search window closes.
- i_ref_valid coinciding with a strobe: the comparison uses the pre-shift ref_sr.

## Structure
- Shared package qpsk_pkg holds:
  - the FSM state enum (IDLE, SEARCH, LOCKED);
  - the SAMPLE_W=16 and OS_FACTOR=4 constants also used by the transmit filter;
  - the DELAY_MAX and WINDOW defaults.
- One natural sub-module, sym_slicer, containing phase_cnt, the strobe, and the registered sliced bit/valid. ber_checker contains ref_sr, the FSM and the counters.

## Test plan
- Loop with matching streams: transmit filter output at phase 0, tx bits = reference PRBS9, i_enable=1 → o_locked high after 130816 clk; o_delay equals the filter group delay in symbols; o_err_count stays 0 over 10000 symbols.
- Inverted reference (i_ref_bit = ~tx bit) → every candidate delay scores the same error count, so the tie rule keeps o_delay=0; in LOCKED, o_err_count equals o_bit_count.
- Every phase, 0 through 3, with i_sample = +100 constant and i_ref_bit=1 → o_sym_valid pulses every 4 clk with the offset set by i_phase; lock is reached with o_delay=0 and errors 0.
- Saturation: force o_bit_count to all-ones minus 2, run 5 symbols → value stays all-ones and does not wrap.
- Reset mid-SEARCH and i_enable dropping in LOCKED → reset: all outputs are 0 next cycle. i_enable drop: o_locked=0 and counters held; re-enable clears the counters and restarts at d=0.
